// File: rtl/bram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_pkg
// Description : Shared types and constants for the bram_arbiter block.
//               It holds the port-id encoding, the read-pipeline stage
//               record and the legal read-latency range.
// Revision    : 1.0 - initial release
// ============================================================================
package bram_pkg;

   localparam int C_RD_LAT_MIN  = 1;
   localparam int C_RD_LAT_MAX  = 3;
   // The stage record is shared by every instance, so its data field is
   // sized for the widest supported word. Narrower words are zero-extended.
   localparam int C_MAX_DATA_W  = 32;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_id_t;

   typedef struct packed {
      logic                    valid;
      port_id_t                port;
      logic [C_MAX_DATA_W-1:0] data;
      logic                    parity;
   } rd_stage_t;

endpackage
`default_nettype wire

// File: rtl/bram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : bram_arbiter_if
// Description : Two-requester req/ack memory bus, with port A (CPU) and
//               port B (DMA/PPU).
//               master : requester side (drives req/we/address/o_data)
//               slave  : memory side (drives ack/i_data/rvalid/perr)
// Revision    : 1.0 - initial release
// ============================================================================
interface bram_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
);
   logic              a_req;
   logic              a_we;
   logic [ADDR_W-1:0] a_address;
   logic [DATA_W-1:0] a_o_data;
   logic              a_ack;
   logic [DATA_W-1:0] a_i_data;
   logic              a_rvalid;
   logic              a_perr;

   logic              b_req;
   logic              b_we;
   logic [ADDR_W-1:0] b_address;
   logic [DATA_W-1:0] b_o_data;
   logic              b_ack;
   logic [DATA_W-1:0] b_i_data;
   logic              b_rvalid;
   logic              b_perr;

   modport master (
      output a_req, a_we, a_address, a_o_data,
      input  a_ack, a_i_data, a_rvalid, a_perr,
      output b_req, b_we, b_address, b_o_data,
      input  b_ack, b_i_data, b_rvalid, b_perr
   );

   modport slave (
      input  a_req, a_we, a_address, a_o_data,
      output a_ack, a_i_data, a_rvalid, a_perr,
      input  b_req, b_we, b_address, b_o_data,
      output b_ack, b_i_data, b_rvalid, b_perr
   );
endinterface
`default_nettype wire

// File: rtl/bram_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module      : bram_rd_pipe
// Description : RD_LAT-deep shift register of read-pipeline stages. Each
//               stage holds {valid, port, data, parity}. Stage 0 loads on the
//               grant edge and the last stage is the read response.
//               Optional macro BRAM_PARITY_EN enables the parity check on the
//               last stage.
// Ports       : clock    - system clock
//               resetn   - synchronous active-low clear of all stages
//               i_stage  - stage captured at the grant edge
//               o_stage  - oldest stage (the response being presented)
//               o_perr   - parity mismatch on a valid o_stage
// Revision    : 1.0 - initial release
// ============================================================================
module bram_rd_pipe
   import bram_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  wire logic clock,
   input  wire logic resetn,
   input  rd_stage_t i_stage,
   output rd_stage_t o_stage,
   output logic      o_perr
);

   rd_stage_t r_stage [RD_LAT];

   always_ff @(posedge clock) begin
      if (!resetn) begin
         for (int i = 0; i < RD_LAT; i++) begin
            r_stage[i] <= '0;
         end
      end else begin
         r_stage[0] <= i_stage;
         for (int i = 1; i < RD_LAT; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_stage = r_stage[RD_LAT-1];

`ifdef BRAM_PARITY_EN
   // The upper data bits are zero, so reducing the whole field gives the
   // parity of the stored word.
   assign o_perr = o_stage.valid & ((^o_stage.data) != o_stage.parity);
`else
   assign o_perr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bram_arbiter
// Description : Single-port block-RAM controller that serves two requesters
//               with round-robin arbitration. One access is granted per
//               cycle. ack pulses one cycle after the grant, and read data
//               returns with rvalid RD_LAT cycles after the grant.
//               Optional macro BRAM_PARITY_EN stores an even-parity bit with
//               each word and flags mismatches on read.
// Ports       : clock  - system clock
//               resetn - synchronous active-low reset
//               bus    - bram_arbiter_if.slave (port A and port B
//                        req/we/address/o_data in, ack/i_data/rvalid/perr out)
// Revision    : 1.0 - initial release
// ============================================================================
module bram_arbiter
   import bram_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input wire logic      clock,
   input wire logic      resetn,
   bram_arbiter_if.slave bus
);

`ifdef BRAM_PARITY_EN
   localparam int C_MEM_W = DATA_W + 1;
`else
   localparam int C_MEM_W = DATA_W;
`endif
   localparam int C_DEPTH = 2 ** ADDR_W;

   if ((RD_LAT < C_RD_LAT_MIN) || (RD_LAT > C_RD_LAT_MAX)) begin : g_bad_rd_lat
      $error("bram_arbiter: RD_LAT must be within 1..3");
   end
   if (DATA_W > C_MAX_DATA_W) begin : g_bad_data_w
      $error("bram_arbiter: DATA_W exceeds the pipeline stage width");
   end

   logic [C_MEM_W-1:0] r_mem [C_DEPTH];

   port_id_t           r_last;      // most recently granted port
   logic               r_a_ack;
   logic               r_b_ack;
   logic [DATA_W-1:0]  r_a_hold;
   logic [DATA_W-1:0]  r_b_hold;

   logic               w_gnt_a;
   logic               w_gnt_b;
   logic               w_gnt;
   logic               w_we;
   logic [ADDR_W-1:0]  w_addr;
   logic [DATA_W-1:0]  w_wdata;
   logic [C_MEM_W-1:0] w_wr_word;
   logic [C_MEM_W-1:0] w_rd_word;
   rd_stage_t          w_stage_in;
   rd_stage_t          w_stage_out;
   logic               w_perr;
   logic [DATA_W-1:0]  w_rd_data;
   logic               w_a_rvalid;
   logic               w_b_rvalid;
   logic               w_unused_bits;

   // On a tie the port that was not granted most recently wins.
   always_comb begin
      w_gnt_a = bus.a_req & (~bus.b_req | (r_last == PORT_B));
      w_gnt_b = bus.b_req & (~bus.a_req | (r_last == PORT_A));
      w_gnt   = w_gnt_a | w_gnt_b;
      w_we    = bus.a_we;
      w_addr  = bus.a_address;
      w_wdata = bus.a_o_data;
      if (w_gnt_b) begin
         w_we    = bus.b_we;
         w_addr  = bus.b_address;
         w_wdata = bus.b_o_data;
      end
   end

`ifdef BRAM_PARITY_EN
   assign w_wr_word = {^w_wdata, w_wdata};
`else
   assign w_wr_word = w_wdata;
`endif

   // Storage has no reset, so its contents survive resetn.
   always_ff @(posedge clock) begin
      if (resetn && w_gnt && w_we) begin
         r_mem[w_addr] <= w_wr_word;
      end
   end

   assign w_rd_word = r_mem[w_addr];

   always_comb begin
      w_stage_in       = '0;
      w_stage_in.valid = resetn & w_gnt & ~w_we;
      w_stage_in.port  = w_gnt_b ? PORT_B : PORT_A;
      w_stage_in.data  = C_MAX_DATA_W'(w_rd_word[DATA_W-1:0]);
`ifdef BRAM_PARITY_EN
      w_stage_in.parity = w_rd_word[DATA_W];
`endif
   end

   bram_rd_pipe #(
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .clock   (clock),
      .resetn  (resetn),
      .i_stage (w_stage_in),
      .o_stage (w_stage_out),
      .o_perr  (w_perr)
   );

   assign w_rd_data  = w_stage_out.data[DATA_W-1:0];
   assign w_a_rvalid = w_stage_out.valid & (w_stage_out.port == PORT_A);
   assign w_b_rvalid = w_stage_out.valid & (w_stage_out.port == PORT_B);
   assign w_unused_bits = ^{w_stage_out.data >> DATA_W, w_stage_out.parity};

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_last   <= PORT_A;
         r_a_ack  <= 1'b0;
         r_b_ack  <= 1'b0;
         r_a_hold <= '0;
         r_b_hold <= '0;
      end else begin
         if (w_gnt) begin
            r_last <= w_gnt_b ? PORT_B : PORT_A;
         end
         r_a_ack <= w_gnt_a;
         r_b_ack <= w_gnt_b;
         if (w_a_rvalid) begin
            r_a_hold <= w_rd_data;
         end
         if (w_b_rvalid) begin
            r_b_hold <= w_rd_data;
         end
      end
   end

   // Read data goes straight out of the last stage. The hold register keeps
   // the last value visible between responses.
   assign bus.a_ack    = r_a_ack;
   assign bus.b_ack    = r_b_ack;
   assign bus.a_rvalid = w_a_rvalid;
   assign bus.b_rvalid = w_b_rvalid;
   assign bus.a_i_data = w_a_rvalid ? w_rd_data : r_a_hold;
   assign bus.b_i_data = w_b_rvalid ? w_rd_data : r_b_hold;
   assign bus.a_perr   = w_a_rvalid & w_perr;
   assign bus.b_perr   = w_b_rvalid & w_perr;

endmodule
`default_nettype wire
